// File: rtl/rtc_ad_write_seq_if.sv
// Handshake and multiplexed AD bus signals between the field controller, the
// write sequencer and the RTC pins. Names carry the sequencer's direction.
interface rtc_ad_write_seq_if;
    logic       i_start;
    logic [7:0] i_addr;
    logic [7:0] i_data_in;
    logic       o_busy;
    logic       o_done;
    logic       o_err;
    logic       o_cs_n;
    logic       o_rd_n;
    logic       o_wr_n;
    logic       o_ad_sel;
    logic       o_ad_oe;
    logic [7:0] o_ad_out;

    modport master (
        output i_start, i_addr, i_data_in,
        input  o_busy, o_done, o_err, o_cs_n, o_rd_n, o_wr_n,
               o_ad_sel, o_ad_oe, o_ad_out
    );

    modport slave (
        input  i_start, i_addr, i_data_in,
        output o_busy, o_done, o_err, o_cs_n, o_rd_n, o_wr_n,
               o_ad_sel, o_ad_oe, o_ad_out
    );
endinterface

// File: rtl/rtc_ad_write_seq.sv
// RTC register write sequencer: address cycle then data cycle on a
// multiplexed AD bus, each phase (setup/strobe/hold) T_PH clocks long.
// Optional macro RTC_BCD_CHECK_EN rejects writes whose data is not valid BCD.
module rtc_ad_write_seq #(
    parameter int unsigned T_PH  = 5,
    parameter int unsigned T_GAP = 2
) (
    input  logic              clk,
    input  logic              reset,
    rtc_ad_write_seq_if.slave bus
);
    localparam logic [7:0] PH_LAST  = 8'(T_PH - 1);
    localparam logic [7:0] GAP_LAST = 8'(T_GAP - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_A_SETUP, S_A_STROBE, S_A_HOLD,
        S_D_SETUP, S_D_STROBE, S_D_HOLD, S_GAP, S_DONE
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_cnt;
    logic [7:0] r_addr;
    logic [7:0] r_data;
    logic       w_ph_end;
    logic       w_can_start;
    logic       w_bad;
    logic       w_accept;

    logic       w_busy, w_done, w_cs_n, w_wr_n, w_ad_sel, w_ad_oe;
    logic [7:0] w_ad_out;
    logic       w_err;
    logic       r_busy, r_done, r_err, r_cs_n, r_wr_n, r_ad_sel, r_ad_oe;
    logic [7:0] r_ad_out;

    assign w_ph_end    = (r_cnt == PH_LAST);
    assign w_can_start = (r_state == S_IDLE) || (r_state == S_DONE);

`ifdef RTC_BCD_CHECK_EN
    logic r_bad;

    assign w_bad = (bus.i_data_in[7:4] > 4'd9) || (bus.i_data_in[3:0] > 4'd9);

    // Remember a rejected request so err pulses one clock later
    always_ff @(posedge clk) begin
        if (reset) r_bad <= 1'b0;
        else       r_bad <= w_can_start && bus.i_start && w_bad;
    end

    assign w_err = r_bad;
`else
    assign w_bad = 1'b0;
    assign w_err = 1'b0;
`endif

    assign w_accept = w_can_start && bus.i_start && !w_bad;

    // State register and phase counter; counter restarts on every state change
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state || r_state == S_IDLE) r_cnt <= 8'd0;
            else                                        r_cnt <= r_cnt + 8'd1;
        end
    end

    // Capture the request so later input changes cannot disturb the transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr <= 8'h00;
            r_data <= 8'h00;
        end else if (w_accept) begin
            r_addr <= bus.i_addr;
            r_data <= bus.i_data_in;
        end
    end

    // Next state and per-state bus values
    always_comb begin
        w_next   = r_state;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        w_cs_n   = 1'b1;
        w_wr_n   = 1'b1;
        w_ad_sel = 1'b1;
        w_ad_oe  = 1'b0;
        w_ad_out = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_A_SETUP;
            end
            S_A_SETUP: begin
                w_busy = 1'b1; w_cs_n = 1'b0; w_ad_sel = 1'b0; w_ad_oe = 1'b1; w_ad_out = r_addr;
                if (w_ph_end) w_next = S_A_STROBE;
            end
            S_A_STROBE: begin
                w_busy = 1'b1; w_cs_n = 1'b0; w_wr_n = 1'b0; w_ad_sel = 1'b0; w_ad_oe = 1'b1;
                w_ad_out = r_addr;
                if (w_ph_end) w_next = S_A_HOLD;
            end
            S_A_HOLD: begin
                w_busy = 1'b1; w_ad_sel = 1'b0; w_ad_oe = 1'b1; w_ad_out = r_addr;
                if (w_ph_end) w_next = S_D_SETUP;
            end
            S_D_SETUP: begin
                w_busy = 1'b1; w_cs_n = 1'b0; w_ad_oe = 1'b1; w_ad_out = r_data;
                if (w_ph_end) w_next = S_D_STROBE;
            end
            S_D_STROBE: begin
                w_busy = 1'b1; w_cs_n = 1'b0; w_wr_n = 1'b0; w_ad_oe = 1'b1; w_ad_out = r_data;
                if (w_ph_end) w_next = S_D_HOLD;
            end
            S_D_HOLD: begin
                w_busy = 1'b1; w_ad_oe = 1'b1; w_ad_out = r_data;
                if (w_ph_end) w_next = (T_GAP == 0) ? S_DONE : S_GAP;
            end
            S_GAP: begin
                w_busy = 1'b1;
                if (r_cnt == GAP_LAST) w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = w_accept ? S_A_SETUP : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output registers: pins follow the state one clock later
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_cs_n   <= 1'b1;
            r_wr_n   <= 1'b1;
            r_ad_sel <= 1'b1;
            r_ad_oe  <= 1'b0;
            r_ad_out <= 8'h00;
        end else begin
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_err    <= w_err;
            r_cs_n   <= w_cs_n;
            r_wr_n   <= w_wr_n;
            r_ad_sel <= w_ad_sel;
            r_ad_oe  <= w_ad_oe;
            r_ad_out <= w_ad_out;
        end
    end

    assign bus.o_busy   = r_busy;
    assign bus.o_done   = r_done;
    assign bus.o_err    = r_err;
    assign bus.o_cs_n   = r_cs_n;
    assign bus.o_rd_n   = 1'b1;
    assign bus.o_wr_n   = r_wr_n;
    assign bus.o_ad_sel = r_ad_sel;
    assign bus.o_ad_oe  = r_ad_oe;
    assign bus.o_ad_out = r_ad_out;
endmodule

// File: tb/tb_rtc_ad_write_seq.sv
// Bench for rtc_ad_write_seq: a default instance (T_PH=5, T_GAP=2) and a fast
// instance (T_PH=1, T_GAP=0), checked cycle by cycle against an expected
// bus timeline derived from the phase timing.
module tb_rtc_ad_write_seq;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rtc_ad_write_seq_if bus0();
    rtc_ad_write_seq_if bus1();

    rtc_ad_write_seq dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    rtc_ad_write_seq #(.T_PH(1), .T_GAP(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    int n_cmp  = 0;
    int n_fail = 0;

    // {busy, done, err, cs_n, rd_n, wr_n, ad_sel, ad_oe, ad_out[7:0]}
    localparam logic [15:0] IDLE_V = {8'b0001_1110, 8'h00};

    typedef struct {
        int         w;
        logic [7:0] addr;
        logic [7:0] data;
        int         exp_lat;
    } vec_t;

    function automatic logic [15:0] get_outs(input int w);
        if (w == 0)
            return {bus0.o_busy, bus0.o_done, bus0.o_err, bus0.o_cs_n, bus0.o_rd_n,
                    bus0.o_wr_n, bus0.o_ad_sel, bus0.o_ad_oe, bus0.o_ad_out};
        return {bus1.o_busy, bus1.o_done, bus1.o_err, bus1.o_cs_n, bus1.o_rd_n,
                bus1.o_wr_n, bus1.o_ad_sel, bus1.o_ad_oe, bus1.o_ad_out};
    endfunction

    task automatic drive(input int w, input logic s, input logic [7:0] a, input logic [7:0] d);
        if (w == 0) begin bus0.i_start = s; bus0.i_addr = a; bus0.i_data_in = d; end
        else        begin bus1.i_start = s; bus1.i_addr = a; bus1.i_data_in = d; end
    endtask

    function automatic logic is_bad(input logic [7:0] d);
`ifdef RTC_BCD_CHECK_EN
        return (d[7:4] > 4'd9) || (d[3:0] > 4'd9);
`else
        return 1'b0;
`endif
    endfunction

    // Expected outputs k clocks after the accepting edge
    function automatic logic [15:0] exp_at(input int w, input int k, input logic [7:0] a,
                                           input logic [7:0] d, input logic bad);
        int t;
        int g;
        int l;
        logic [15:0] v;
        t = (w == 0) ? 5 : 1;
        g = (w == 0) ? 2 : 0;
        l = 6 * t + g + 1;
        v = IDLE_V;
        if (bad) begin
            if (k == 1) v[13] = 1'b1;
            return v;
        end
        if (k >= 1 && k <= 6 * t) begin
            case ((k - 1) / t)
                0: v = {8'b1000_1101, a};
                1: v = {8'b1000_1001, a};
                2: v = {8'b1001_1101, a};
                3: v = {8'b1000_1111, d};
                4: v = {8'b1000_1011, d};
                default: v = {8'b1001_1111, d};
            endcase
        end else if (k > 6 * t && k < l) begin
            v[15] = 1'b1;
        end else if (k == l) begin
            v[14] = 1'b1;
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Compare outputs at the negedges for k = k0..k1; report first done seen
    task automatic window(input int w, input logic [7:0] a, input logic [7:0] d, input logic bad,
                          input int k0, input int k1, output int fd);
        logic [15:0] act;
        fd = 0;
        for (int k = k0; k <= k1; k++) begin
            @(negedge clk);
            act = get_outs(w);
            check($sformatf("w%0d a%h d%h k%0d", w, a, d, k), 32'(act),
                  32'(exp_at(w, k, a, d, bad)));
            if (act[14] && fd == 0) fd = k;
        end
    endtask

    // Present a one-clock start, then scramble inputs after acceptance
    task automatic start_xfer(input int w, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        drive(w, 1'b1, a, d);
        @(posedge clk);
        #1 drive(w, 1'b0, 8'hEE, 8'hEE);
    endtask

    vec_t vecs[6];
    int   fd;
    int   fd2;

    initial begin
        vecs[0] = '{0, 8'h02, 8'h59, 33};
        vecs[1] = '{0, 8'h12, 8'h34, 33};
        vecs[2] = '{1, 8'h02, 8'h59, 7};
        vecs[3] = '{1, 8'h45, 8'h99, 7};
`ifdef RTC_BCD_CHECK_EN
        vecs[4] = '{0, 8'h0A, 8'h5A, 0};
        vecs[5] = '{1, 8'h7F, 8'hA0, 0};
`else
        vecs[4] = '{0, 8'h0A, 8'h5A, 33};
        vecs[5] = '{1, 8'h7F, 8'hA0, 7};
`endif

        reset = 1'b1;
        drive(0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_w0", 32'(get_outs(0)), 32'(IDLE_V));
        check("reset_w1", 32'(get_outs(1)), 32'(IDLE_V));
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single writes from the vector table
        for (int i = 0; i < 6; i++) begin
            start_xfer(vecs[i].w, vecs[i].addr, vecs[i].data);
            window(vecs[i].w, vecs[i].addr, vecs[i].data, is_bad(vecs[i].data),
                   0, ((vecs[i].w == 0) ? 33 : 7) + 1, fd);
            check($sformatf("latency v%0d", i), 32'(fd), 32'(vecs[i].exp_lat));
        end

        // Back-to-back: start held high, second pair accepted in DONE
        @(negedge clk);
        drive(0, 1'b1, 8'h02, 8'h59);
        @(posedge clk);
        #1 drive(0, 1'b1, 8'h03, 8'h00);
        window(0, 8'h02, 8'h59, 1'b0, 0, 33, fd);
        drive(0, 1'b0, 8'h03, 8'h00);
        window(0, 8'h03, 8'h00, 1'b0, 1, 34, fd2);
        check("b2b first done", 32'(fd), 32'd33);
        check("b2b done spacing", 32'(fd2), 32'd33);

        // Start pulsed during D_STROBE is ignored
        start_xfer(0, 8'h12, 8'h34);
        window(0, 8'h12, 8'h34, 1'b0, 0, 21, fd);
        drive(0, 1'b1, 8'h77, 8'h11);
        window(0, 8'h12, 8'h34, 1'b0, 22, 22, fd);
        drive(0, 1'b0, 8'h77, 8'h11);
        window(0, 8'h12, 8'h34, 1'b0, 23, 34, fd);
        check("ignored start latency", 32'(fd), 32'd33);

        // Reset in A_STROBE, then silence, then a normal write
        start_xfer(0, 8'h02, 8'h59);
        window(0, 8'h02, 8'h59, 1'b0, 0, 8, fd);
        reset = 1'b1;
        @(negedge clk);
        check("reset mid w0", 32'(get_outs(0)), 32'(IDLE_V));
        reset = 1'b0;
        fd = 0;
        for (int k = 0; k < 36; k++) begin
            @(negedge clk);
            if (get_outs(0) !== IDLE_V) fd++;
        end
        check("post reset idle cycles off", 32'(fd), 32'd0);
        start_xfer(0, 8'h21, 8'h47);
        window(0, 8'h21, 8'h47, 1'b0, 0, 34, fd);
        check("after reset latency", 32'(fd), 32'd33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
